fetch_sequencer: RTL and testbench

- Instruction-fetch and sequencing front end for the 8-bit core; produces what the instruction decoder consumes.
- Generates the four one-hot execution phases from the single clock, holds the program counter, reads program memory and loads the instruction register.
- Resolves control flow (GOTO, CALL, RETURN, skip) with a two-stage fetch/execute overlap and flush-to-NOP.

---
 rtl/fetch_sequencer_pkg.sv | 37 +++
 rtl/fetch_sequencer_return_stack.sv | 82 ++++++++
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 tb/tb_fetch_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch front end: the one-hot
//   execution phases, the NOP/RETURN opcodes, the branch class codes and
//   the opcode match helpers used by the sequencer.
// -----------------------------------------------------------------------------
package fetch_pkg;

   // One-hot execution phase; bit0 = Q1. The encoding doubles as the
   // decoder clock enables, so the enum value is driven out directly.
   typedef enum logic [3:0] {
      Q1 = 4'b0001,
      Q2 = 4'b0010,
      Q3 = 4'b0100,
      Q4 = 4'b1000
   } phase_t;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_RETURN = 8'h80;

   localparam logic [2:0] CLS_GOTO = 3'b101;
   localparam logic [2:0] CLS_CALL = 3'b100;

   function automatic logic is_return(input logic [7:0] inst);
      return inst == OP_RETURN;
   endfunction

   function automatic logic is_goto(input logic [7:0] inst);
      return inst[7:5] == CLS_GOTO;
   endfunction

   // CALL 0 shares its encoding with RETURN, so a zero target is never a call.
   function automatic logic is_call(input logic [7:0] inst);
      return (inst[7:5] == CLS_CALL) && (inst[4:0] != 5'd0);
   endfunction

endpackage

// File: rtl/fetch_sequencer_return_stack.sv
// -----------------------------------------------------------------------------
// return_stack
//   Hardware LIFO of return addresses with a circular pointer.
//   A push while full overwrites the oldest entry and sets the sticky ovf
//   flag. A pop while empty returns nothing useful, parks the pointer at 0
//   and sets the sticky unf flag. Flags clear only on rst.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_data at the pointer and advance it
//   pop         step the pointer back (pop_data is valid in the same cycle)
//   push_data   return address to save
//   pop_data    entry below the pointer (top of stack), combinational
//   empty       no outstanding pushes
//   ovf, unf    sticky overflow / underflow flags
// push and pop are never asserted together by the sequencer; push wins.
// -----------------------------------------------------------------------------
module return_stack #(
   parameter int STACK_DEPTH = 2,
   parameter int PC_W        = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] push_data,
   output logic [PC_W-1:0] pop_data,
   output logic            empty,
   output logic            ovf,
   output logic            unf
);

   localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   // Nesting depth is tracked past STACK_DEPTH so that pops after an
   // overflow keep returning (wrapped) entries until the true depth is used up.
   localparam int CNT_W = PC_W + 1;
   localparam logic [PTR_W-1:0] SP_MAX  = PTR_W'(STACK_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_CAP = {CNT_W{1'b1}};

   logic [PC_W-1:0]  entries [STACK_DEPTH];
   logic [PTR_W-1:0] sp;
   logic [PTR_W-1:0] sp_inc;
   logic [PTR_W-1:0] sp_dec;
   logic [CNT_W-1:0] depth;
   logic             full;

   assign sp_inc   = (sp == SP_MAX) ? '0 : sp + PTR_W'(1);
   assign sp_dec   = (sp == '0) ? SP_MAX : sp - PTR_W'(1);
   assign pop_data = entries[sp_dec];
   assign empty    = (depth == '0);
   assign full     = (depth >= CNT_W'(STACK_DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp    <= '0;
         depth <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (push) begin
         entries[sp] <= push_data;
         sp          <= sp_inc;
         if (full) begin
            ovf <= 1'b1;
         end
         if (depth != CNT_CAP) begin
            depth <= depth + CNT_W'(1);
         end
      end else if (pop) begin
         if (empty) begin
            sp  <= '0;
            unf <= 1'b1;
         end else begin
            sp    <= sp_dec;
            depth <= depth - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Instruction fetch / sequencing front end. Rotates the four one-hot
//   phases, holds the program counter, fetches from program memory and
//   loads the instruction register. Fetch of I(n+1) overlaps execution of
//   I(n); taken branches and skips replace the prefetched word with NOP.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   halt         freezes the phase counter and all state while high
//   skip_req     discard the prefetched instruction (sampled at the Q4 edge)
//   prog_data    program-memory read data (combinational from prog_addr)
//   prog_addr    program-memory address (= pc)
//   pc           program counter
//   phase_q      one-hot phase, bit0 = Q1
//   inst_reg     instruction currently executing
//   stack_ovf    sticky: CALL with the return stack full
//   stack_unf    sticky: RETURN with the return stack empty
// -----------------------------------------------------------------------------
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int PC_W        = 8,
   parameter int STACK_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            halt,
   input  logic            skip_req,
   input  logic [7:0]      prog_data,
   output logic [PC_W-1:0] prog_addr,
   output logic [PC_W-1:0] pc,
   output logic [3:0]      phase_q,
   output logic [7:0]      inst_reg,
   output logic            stack_ovf,
   output logic            stack_unf
);

   phase_t          phase_r;
   phase_t          phase_next;
   logic            step;
   logic [PC_W-1:0] pc_r;
   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] target;
   logic [7:0]      inst_r;
   logic [7:0]      inst_next;
   logic            push;
   logic            pop;
   logic [PC_W-1:0] pop_data;
   logic            stack_empty;

   // Phase state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_r <= Q1;
      end else if (!halt) begin
         phase_r <= phase_next;
      end
   end

   // Phase next-state.
   always_comb begin
      phase_next = Q1;
      case (phase_r)
         Q1:      phase_next = Q2;
         Q2:      phase_next = Q3;
         Q3:      phase_next = Q4;
         Q4:      phase_next = Q1;
         default: phase_next = Q1;
      endcase
   end

   // Architectural state only moves on the unhalted Q4 edge.
   assign step   = (phase_r == Q4) && !halt;
   assign target = PC_W'(inst_r[4:0]);

   // Control-flow resolution; branches take priority over skip_req.
   always_comb begin
      pc_next   = pc_r + PC_W'(1);
      inst_next = prog_data;
      push      = 1'b0;
      pop       = 1'b0;
      if (is_return(inst_r)) begin
         pop       = step;
         pc_next   = stack_empty ? '0 : pop_data;
         inst_next = OP_NOP;
      end else if (is_goto(inst_r)) begin
         pc_next   = target;
         inst_next = OP_NOP;
      end else if (is_call(inst_r)) begin
         push      = step;
         pc_next   = target;
         inst_next = OP_NOP;
      end else if (skip_req) begin
         inst_next = OP_NOP;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r   <= '0;
         inst_r <= OP_NOP;
      end else if (step) begin
         pc_r   <= pc_next;
         inst_r <= inst_next;
      end
   end

   // pc already points at the return address (the word after the CALL).
   return_stack #(
      .STACK_DEPTH (STACK_DEPTH),
      .PC_W        (PC_W)
   ) u_return_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (pc_r),
      .pop_data  (pop_data),
      .empty     (stack_empty),
      .ovf       (stack_ovf),
      .unf       (stack_unf)
   );

   assign phase_q   = phase_r;
   assign pc        = pc_r;
   assign prog_addr = pc_r;
   assign inst_reg  = inst_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer (PC_W=8, STACK_DEPTH=2). Program memory
//   is a combinational array model; each scenario loads its program, resets
//   the DUT and compares against hand-computed values one ns after clk edges.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       halt = 1'b0;
   logic       skip_req = 1'b0;
   logic [7:0] prog_data;
   logic [7:0] prog_addr;
   logic [7:0] pc;
   logic [3:0] phase_q;
   logic [7:0] inst_reg;
   logic       stack_ovf;
   logic       stack_unf;

   logic [7:0] mem [256];
   int total = 0;
   int bad   = 0;

   assign prog_data = mem[prog_addr];

   fetch_sequencer #(.PC_W(8), .STACK_DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .halt      (halt),
      .skip_req  (skip_req),
      .prog_data (prog_data),
      .prog_addr (prog_addr),
      .pc        (pc),
      .phase_q   (phase_q),
      .inst_reg  (inst_reg),
      .stack_ovf (stack_ovf),
      .stack_unf (stack_unf)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic apply_reset();
      halt     = 1'b0;
      skip_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_state(input string name, input logic [3:0] exp_phase,
                              input logic [7:0] exp_pc, input logic [7:0] exp_inst);
      total++;
      if (phase_q !== exp_phase || pc !== exp_pc || inst_reg !== exp_inst || prog_addr !== exp_pc) begin
         bad++;
         $display("FAIL %s: phase=%h pc=%h addr=%h inst=%h, want phase=%h pc=%h inst=%h",
                  name, phase_q, pc, prog_addr, inst_reg, exp_phase, exp_pc, exp_inst);
      end
   endtask

   task automatic check_flags(input string name, input logic exp_ovf, input logic exp_unf);
      total++;
      if (stack_ovf !== exp_ovf || stack_unf !== exp_unf) begin
         bad++;
         $display("FAIL %s: ovf=%b unf=%b, want ovf=%b unf=%b",
                  name, stack_ovf, stack_unf, exp_ovf, exp_unf);
      end
   endtask

   // Scenarios
   task automatic test_reset();
      clear_mem();
      apply_reset();
      check_state("reset_state", 4'b0001, 8'd0, 8'h00);
      check_flags("reset_flags", 1'b0, 1'b0);
   endtask

   task automatic test_linear();
      clear_mem();
      mem[0] = 8'h1C; mem[1] = 8'h05; mem[2] = 8'h0A; mem[3] = 8'hC3;
      apply_reset();
      tick(1); check_state("lin_clk1", 4'b0010, 8'd0, 8'h00);
      tick(1); check_state("lin_clk2", 4'b0100, 8'd0, 8'h00);
      tick(1); check_state("lin_clk3", 4'b1000, 8'd0, 8'h00);
      tick(1); check_state("lin_clk4", 4'b0001, 8'd1, 8'h1C);
      tick(4); check_state("lin_clk8", 4'b0001, 8'd2, 8'h05);
      tick(4); check_state("lin_clk12", 4'b0001, 8'd3, 8'h0A);
      tick(4); check_state("lin_clk16", 4'b0001, 8'd4, 8'hC3);
   endtask

   task automatic test_goto();
      clear_mem();
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'hA9; mem[9] = 8'h33;
      apply_reset();
      tick(12); check_state("goto_exec", 4'b0001, 8'd3, 8'hA9);
      tick(4);  check_state("goto_flush", 4'b0001, 8'd9, 8'h00);
      tick(4);  check_state("goto_target", 4'b0001, 8'd10, 8'h33);
   endtask

   task automatic test_call_return();
      clear_mem();
      mem[0] = 8'h01; mem[1] = 8'h8A; mem[2] = 8'h44; mem[10] = 8'h80;
      apply_reset();
      tick(8);  check_state("call_exec", 4'b0001, 8'd2, 8'h8A);
      tick(4);  check_state("call_flush", 4'b0001, 8'd10, 8'h00);
      tick(4);  check_state("call_body", 4'b0001, 8'd11, 8'h80);
      tick(4);  check_state("ret_flush", 4'b0001, 8'd2, 8'h00);
      tick(4);  check_state("ret_resume", 4'b0001, 8'd3, 8'h44);
      check_flags("callret_flags", 1'b0, 1'b0);
   endtask

   task automatic test_overflow_underflow();
      clear_mem();
      // CALL 2 -> CALL 4 -> CALL 6 (pushes 1, 3, 5), then RETURN x4.
      mem[0] = 8'h82; mem[2] = 8'h84; mem[4] = 8'h86;
      mem[6] = 8'h80; mem[5] = 8'h80; mem[3] = 8'h80;
      apply_reset();
      tick(20); check_flags("ovf_two_calls", 1'b0, 1'b0);
      tick(4);  check_state("ovf_third_call", 4'b0001, 8'd6, 8'h00);
      check_flags("ovf_set", 1'b1, 1'b0);
      tick(8);  check_state("ret1_pop5", 4'b0001, 8'd5, 8'h00);
      tick(8);  check_state("ret2_pop3", 4'b0001, 8'd3, 8'h00);
      tick(8);  check_state("ret3_wrapped5", 4'b0001, 8'd5, 8'h00);
      check_flags("ret3_no_unf", 1'b1, 1'b0);
      tick(8);  check_state("ret4_empty", 4'b0001, 8'd0, 8'h00);
      check_flags("unf_set", 1'b1, 1'b1);
      tick(8);  check_flags("flags_sticky", 1'b1, 1'b1);
      apply_reset();
      check_flags("flags_cleared", 1'b0, 1'b0);
   endtask

   task automatic test_skip();
      clear_mem();
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
      mem[4] = 8'h05; mem[6] = 8'hA3;
      apply_reset();
      tick(20); check_state("skip_pre", 4'b0001, 8'd5, 8'h05);
      skip_req = 1'b1;
      tick(4);  check_state("skip_nop", 4'b0001, 8'd6, 8'h00);
      skip_req = 1'b0;
      tick(4);  check_state("skip_goto_exec", 4'b0001, 8'd7, 8'hA3);
      skip_req = 1'b1;
      tick(4);  check_state("skip_goto_wins", 4'b0001, 8'd3, 8'h00);
      skip_req = 1'b0;
   endtask

   task automatic test_halt_and_async_reset();
      clear_mem();
      mem[0] = 8'h11; mem[1] = 8'h22;
      apply_reset();
      tick(5); check_state("halt_pre", 4'b0010, 8'd1, 8'h11);
      halt = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick(1);
         check_state($sformatf("halt_frozen_%0d", i), 4'b0010, 8'd1, 8'h11);
      end
      halt = 1'b0;
      tick(3); check_state("halt_resume", 4'b0001, 8'd2, 8'h22);
      tick(2); check_state("mid_q3", 4'b0100, 8'd2, 8'h22);
      #3;
      rst = 1'b1;
      #1;
      check_state("async_reset", 4'b0001, 8'd0, 8'h00);
      check_flags("async_reset_flags", 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Main sequence and report
   initial begin
      test_reset();
      test_linear();
      test_goto();
      test_call_return();
      test_overflow_underflow();
      test_skip();
      test_halt_and_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
